// File: rtl/lm07_serial_responder.sv
// LM07 sensor-side serial responder: holds a saturated temperature word and
// shifts it out MSB first as a 16-bit frame while the master holds CS low.
module lm07_serial_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int T_MAX       = 2400,
  parameter int T_MIN       = -880
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] temp_in,
  input  logic        temp_valid,
  input  logic        cs_n,
  input  logic        sclk,
  output logic        sio_out,
  output logic        sio_oe,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned HOLD_W  = 13;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
  logic                   cs_prev, sclk_prev;
  logic                   cs_s, sclk_s;
  logic                   cs_fall, cs_rise, sclk_fall, sclk_rise;

  logic signed [15:0]     t_in_s, t_max_s, t_min_s;
  logic [HOLD_W-1:0]      sat_val, hold;

  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sio_out_d, sio_oe_d, busy_d, done_d, abort_d;

  // Resample the asynchronous master signals; flops idle high like the bus
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_prev   <= cs_sync[SYNC_STAGES-1];
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign sclk_fall = sclk_prev & ~sclk_s;
  assign sclk_rise = ~sclk_prev & sclk_s;

  // Clamp the incoming temperature to the reportable range (signed compare)
  assign t_in_s  = temp_in;
  assign t_max_s = 16'(T_MAX);
  assign t_min_s = 16'(T_MIN);
  always_comb begin
    sat_val = HOLD_W'(t_in_s);
    if (t_in_s > t_max_s)      sat_val = HOLD_W'(t_max_s);
    else if (t_in_s < t_min_s) sat_val = HOLD_W'(t_min_s);
  end

  // Holding register updates on every strobe regardless of frame activity
  always_ff @(posedge clk) begin
    if (!reset)          hold <= '0;
    else if (temp_valid) hold <= sat_val;
  end

  // State, shift register, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      sio_out     <= 1'b0;
      sio_oe      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      sio_out     <= sio_out_d;
      sio_oe      <= sio_oe_d;
      busy        <= busy_d;
      frame_done  <= done_d;
      frame_abort <= abort_d;
    end
  end

  // Next-state and next-output logic; a CS release overrides any SCLK edge
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    sio_out_d = sio_out;
    sio_oe_d  = sio_oe;
    busy_d    = busy;
    done_d    = 1'b0;
    abort_d   = 1'b0;

    case (state_q)
      IDLE: begin
        sio_out_d = 1'b0;
        sio_oe_d  = 1'b0;
        busy_d    = 1'b0;
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        // The shift register doubles as the frame snapshot of hold
        shift_d   = {hold, 3'b111};
        cnt_d     = '0;
        sio_out_d = hold[HOLD_W-1];
        sio_oe_d  = 1'b1;
        busy_d    = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: begin
        sio_oe_d = 1'b1;
        busy_d   = 1'b1;
        if (sclk_rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            done_d    = 1'b1;
            sio_out_d = 1'b0;
            state_d   = DONE;
          end
        end else if (sclk_fall && cnt_q != '0) begin
          shift_d   = shift_q << 1;
          sio_out_d = shift_q[FRAME_W-2];
        end
      end
      DONE: begin
        sio_out_d = 1'b0;
        sio_oe_d  = 1'b1;
        busy_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && cs_rise) begin
      state_d   = IDLE;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      sio_out_d = 1'b0;
      sio_oe_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      abort_d   = (state_q != DONE);
    end
  end

endmodule

// File: tb/tb_lm07_serial_responder.sv
// Bench for lm07_serial_responder: a master-side driver issues frames and
// queues expected results; a monitor checks each done/abort pulse.
module tb_lm07_serial_responder;

  localparam int SS    = 2;
  localparam int T_MAX = 2400;
  localparam int T_MIN = -880;

  logic        clk = 1'b0;
  logic        reset, temp_valid, cs_n, sclk;
  logic [15:0] temp_in;
  logic        sio_out, sio_oe, busy, frame_done, frame_abort;

  lm07_serial_responder #(.SYNC_STAGES(SS), .T_MAX(T_MAX), .T_MIN(T_MIN)) dut (
    .clk(clk), .reset(reset), .temp_in(temp_in), .temp_valid(temp_valid),
    .cs_n(cs_n), .sclk(sclk), .sio_out(sio_out), .sio_oe(sio_oe),
    .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [15:0] data;
    int          nbits;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_hold = 0;
  logic rx[0:31];
  int   rx_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference saturation on plain integers
  function automatic int sat(input logic [15:0] v);
    int x;
    x = int'($signed(v));
    if (x > T_MAX) return T_MAX;
    if (x < T_MIN) return T_MIN;
    return x;
  endfunction

  function automatic logic [15:0] frame_of(input int h);
    int w;
    w = ((h & 32'h1FFF) << 3) | 7;
    return 16'(w);
  endfunction

  // Called on a negedge; strobes temp_valid for one clock
  task automatic load_temp(input int v);
    temp_in    = 16'(v);
    temp_valid = 1'b1;
    model_hold = sat(16'(v));
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  // One CS-low transaction with n SCLK cycles; optional hold update after bit upd_at
  task automatic transfer(input int n, input int upd_at, input int upd_val);
    exp_t e;
    @(negedge clk);
    cs_n = 1'b0;
    rx_n = 0;
    e.is_done = (n >= 16);
    e.nbits   = (n >= 16) ? 16 : n;
    e.data    = frame_of(model_hold);
    exp_q.push_back(e);
    repeat (6) @(negedge clk);
    check("oe_on", 32'(sio_oe), 32'd1);
    check("busy_on", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      rx[i] = sio_out;
      rx_n  = i + 1;
      if (i + 1 == upd_at) begin
        load_temp(upd_val);
        repeat (4) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
    end
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_off", 32'(busy), 32'd0);
    check("oe_off", 32'(sio_oe), 32'd0);
    for (int k = 16; k < n; k++) check("overclock_bit", 32'(rx[k]), 32'd0);
  endtask

  // Monitor: every completion or abort pulse consumes one expectation
  always @(negedge clk) begin
    if (reset && (frame_done || frame_abort)) begin
      check("pulse_excl", 32'(frame_done && frame_abort), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: done=%0b abort=%0b with nothing queued", frame_done, frame_abort);
      end else begin
        exp_t        e;
        logic [15:0] got, want;
        e    = exp_q.pop_front();
        got  = '0;
        want = '0;
        check("pulse_kind", 32'(frame_done), 32'(e.is_done));
        check("bit_count", 32'(rx_n), 32'(e.nbits));
        for (int k = 0; k < e.nbits && k < 16; k++) begin
          got[15-k]  = rx[k];
          want[15-k] = e.data[15-k];
        end
        check("frame_data", 32'(got), 32'(want));
      end
    end
  end

  initial begin
    reset      = 1'b0;
    temp_valid = 1'b0;
    temp_in    = '0;
    cs_n       = 1'b1;
    sclk       = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_sio_out", 32'(sio_out), 32'd0);
    check("rst_sio_oe", 32'(sio_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Directed frames: nominal, negative, both saturation limits
    @(negedge clk); load_temp(400);   transfer(16, 0, 0);
    @(negedge clk); load_temp(-400);  transfer(16, 0, 0);
    @(negedge clk); load_temp(3200);  transfer(16, 0, 0);
    @(negedge clk); load_temp(-1600); transfer(16, 0, 0);

    // Hold update mid-frame must only affect the next frame
    @(negedge clk); load_temp(400);
    transfer(16, 5, 800);
    transfer(16, 0, 0);

    // Early CS release then a clean frame
    transfer(7, 0, 0);
    transfer(16, 0, 0);

    // Over-clocking: extra bits read zero, one done pulse
    transfer(20, 0, 0);

    // Reset in the middle of a frame
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b0; repeat (5) @(negedge clk);
      sclk = 1'b1; repeat (5) @(negedge clk);
    end
    check("mid_oe_before_reset", 32'(sio_oe), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_sio_out", 32'(sio_out), 32'd0);
    check("mid_rst_sio_oe", 32'(sio_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    check("mid_rst_abort", 32'(frame_abort), 32'd0);
    cs_n = 1'b1;
    sclk = 1'b1;
    repeat (6) @(negedge clk);
    reset      = 1'b1;
    model_hold = 0;
    repeat (4) @(negedge clk);
    transfer(16, 0, 0);

    // Randomized temperatures, frame lengths and mid-frame updates
    for (int t = 0; t < 30; t++) begin
      int v, r, n, u;
      v = int'($urandom_range(0, 8000)) - 4000;
      r = int'($urandom_range(0, 9));
      if (r < 6)      n = 16;
      else if (r < 8) n = int'($urandom_range(0, 15));
      else            n = int'($urandom_range(17, 20));
      u = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
      @(negedge clk);
      load_temp(v);
      transfer(n, u, int'($urandom_range(0, 8000)) - 4000);
    end

    repeat (10) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
